// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, oversample sample positions and
// tick-accumulator sizing, common to the RX and TX oversampling engines.
`timescale 1ns/1ps
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BRK_WAIT
    } rx_state_t;

    // The three majority-vote samples straddle mid-bit; the decision lands on the last one.
    function automatic int samp_lo(input int os);
        return os / 2 - 1;
    endfunction

    function automatic int samp_mid(input int os);
        return os / 2;
    endfunction

    function automatic int samp_hi(input int os);
        return os / 2 + 1;
    endfunction

    function automatic int acc_width(input int clk_hz, input int inc);
        return $clog2(clk_hz + inc) + 1;
    endfunction

endpackage

// File: rtl/uart_os_tick.sv
// Fractional oversample tick generator: one-cycle o_tick at BAUD*OVERSAMPLE on average,
// with at most one CLK of jitter.
`timescale 1ns/1ps
module uart_os_tick
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = 27000000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16
) (
    input  logic CLK,
    input  logic RST,
    output logic o_tick
);

    localparam int INC = BAUD * OVERSAMPLE;
    localparam int AW  = acc_width(CLK_HZ, INC);
    localparam logic [AW-1:0] INC_W = AW'(INC);
    localparam logic [AW-1:0] CLK_W = AW'(CLK_HZ);

    logic [AW-1:0] acc;
    logic [AW-1:0] sum;

    assign sum = acc + INC_W;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            acc    <= '0;
            o_tick <= 1'b0;
        end else if (sum >= CLK_W) begin
            acc    <= sum - CLK_W;
            o_tick <= 1'b1;
        end else begin
            acc    <= sum;
            o_tick <= 1'b0;
        end
    end

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver with majority-vote sampling, frame/break/overrun detection
// and a valid/ready output. Define UART_RX_PARITY_EN to expect and check a parity bit.
`timescale 1ns/1ps
module uart_rx_os
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = 27000000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 RXD,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [DATA_BITS-1:0] o_data,
    output logic                 o_frame_err,
    output logic                 o_par_err,
    output logic                 o_break,
    output logic                 o_overrun,
    output logic                 o_busy
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0] S_LO  = CW'(samp_lo(OVERSAMPLE));
    localparam logic [CW-1:0] S_MID = CW'(samp_mid(OVERSAMPLE));
    localparam logic [CW-1:0] S_HI  = CW'(samp_hi(OVERSAMPLE));
    localparam logic [CW-1:0] S_END = CW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);
    localparam logic          LAST_STOP = 1'(STOP_BITS - 1);
`ifdef UART_RX_PARITY_EN
    localparam logic PAR_ODD = (PARITY_ODD != 0);
`endif

    logic                 rx_meta, rxs;
    logic                 tick;
    rx_state_t            state;
    logic [CW-1:0]        os_cnt;
    logic [1:0]           samp;
    logic                 maj, decide, bit_end;
    logic [DATA_BITS-1:0] shreg;
    logic [BW-1:0]        bit_cnt;
    logic                 stop_cnt;
    logic                 par_bit, par_err_r, fe_r, stop_one, busy;
    logic                 done, done_fe, done_pe, done_brk;
    logic [DATA_BITS-1:0] done_data;

    uart_os_tick #(
        .CLK_HZ     (CLK_HZ),
        .BAUD       (BAUD),
        .OVERSAMPLE (OVERSAMPLE)
    ) u_tick (
        .CLK    (CLK),
        .RST    (RST),
        .o_tick (tick)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= RXD;
            rxs     <= rx_meta;
        end
    end

    assign maj     = (samp[0] & samp[1]) | (samp[0] & rxs) | (samp[1] & rxs);
    assign decide  = tick && (os_cnt == S_HI);
    assign bit_end = tick && (os_cnt == S_END);
    assign o_busy  = busy;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state     <= IDLE;
            os_cnt    <= '0;
            samp      <= 2'b11;
            shreg     <= '0;
            bit_cnt   <= '0;
            stop_cnt  <= 1'b0;
            par_bit   <= 1'b0;
            par_err_r <= 1'b0;
            fe_r      <= 1'b0;
            stop_one  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            done_data <= '0;
            done_fe   <= 1'b0;
            done_pe   <= 1'b0;
            done_brk  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (tick && os_cnt == S_LO)  samp[0] <= rxs;
            if (tick && os_cnt == S_MID) samp[1] <= rxs;
            if (tick && state != IDLE && state != BRK_WAIT)
                os_cnt <= (os_cnt == S_END) ? '0 : os_cnt + 1'b1;

            case (state)
                IDLE: begin
                    os_cnt <= '0;
                    if (!rxs) begin
                        state     <= START;
                        busy      <= 1'b1;
                        bit_cnt   <= '0;
                        stop_cnt  <= 1'b0;
                        par_bit   <= 1'b0;
                        par_err_r <= 1'b0;
                        fe_r      <= 1'b0;
                        stop_one  <= 1'b0;
                    end
                end
                START: begin
                    // A start bit that votes high was line noise: drop it silently.
                    if (decide && maj) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (bit_end) begin
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (decide) shreg <= {maj, shreg[DATA_BITS-1:1]};
                    if (bit_end) begin
                        if (bit_cnt == LAST_BIT) begin
                            bit_cnt <= '0;
`ifdef UART_RX_PARITY_EN
                            state   <= PARITY;
`else
                            state   <= STOP;
`endif
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (decide) begin
                        par_bit   <= maj;
                        par_err_r <= ((^shreg) ^ maj) != PAR_ODD;
                    end
                    if (bit_end) state <= STOP;
                end
`endif
                STOP: begin
                    if (decide) begin
                        if (stop_cnt == LAST_STOP) begin
                            // Finish at mid-stop so a back-to-back start edge is not missed.
                            done      <= 1'b1;
                            done_data <= shreg;
                            done_fe   <= fe_r | ~maj;
                            done_pe   <= par_err_r;
                            done_brk  <= (shreg == '0) && !par_bit && !stop_one && !maj;
                            busy      <= 1'b0;
                            os_cnt    <= '0;
                            if ((shreg == '0) && !par_bit && !stop_one && !maj)
                                state <= BRK_WAIT;
                            else
                                state <= IDLE;
                        end else begin
                            fe_r     <= fe_r | ~maj;
                            stop_one <= stop_one | maj;
                        end
                    end else if (bit_end) begin
                        stop_cnt <= stop_cnt + 1'b1;
                    end
                end
                BRK_WAIT: begin
                    if (!rxs) begin
                        os_cnt <= '0;
                    end else if (tick) begin
                        if (os_cnt == S_END) state <= IDLE;
                        else                 os_cnt <= os_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Output handshake: a word transfers on a cycle where o_valid && i_ready; o_valid and
    // all word fields hold until then. A new word that finds the slot full is dropped and
    // flagged in o_overrun; one arriving on the accept cycle replaces the accepted word.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            o_valid     <= 1'b0;
            o_data      <= '0;
            o_frame_err <= 1'b0;
            o_par_err   <= 1'b0;
            o_break     <= 1'b0;
            o_overrun   <= 1'b0;
        end else begin
            if (o_valid && i_ready) begin
                o_valid   <= 1'b0;
                o_overrun <= 1'b0;
            end
            if (done) begin
                if (o_valid && !i_ready) begin
                    o_overrun <= 1'b1;
                end else begin
                    o_valid     <= 1'b1;
                    o_data      <= done_data;
                    o_frame_err <= done_fe;
                    o_par_err   <= done_pe;
                    o_break     <= done_brk;
                end
            end
        end
    end

endmodule
